// File: rtl/add_sub_serial.sv
// Multi-cycle N-bit adder/subtractor that processes one W-bit slice per clock.
// It reuses a W-bit adder_n and uses valid/ready handshakes on the operand and result sides.

module adder_n #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] sum,
   output logic         c_out
);
   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + (N+1)'(c_in);
endmodule

module add_sub_serial #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] result,
   output logic         c_out,
   output logic         overflow,
   output logic         zero
);
   localparam int SLICES = N / W;
   localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

   generate
      if (N % W != 0) begin : g_bad_width
         $error("add_sub_serial: N (%0d) must be a multiple of W (%0d)", N, W);
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_next;
   logic [N-1:0]    a_reg, b_reg;
   logic            carry;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    a_slice, b_slice, sum;
   logic            slice_cout;
   logic            last;
   logic [N-1:0]    result_next;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int k = 0; k < SLICES; k++) begin
         if (cnt == CW'(k)) begin
            a_slice = a_reg[k*W +: W];
            b_slice = b_reg[k*W +: W];
         end
      end
   end

   adder_n #(.N(W)) u_adder (
      .a     (a_slice),
      .b     (b_slice),
      .c_in  (carry),
      .sum   (sum),
      .c_out (slice_cout)
   );

   // Only the active slice of the result changes; older bits keep their values.
   always_comb begin
      result_next = result;
      for (int k = 0; k < SLICES; k++) begin
         if (cnt == CW'(k)) result_next[k*W +: W] = sum;
      end
   end

   assign last = (cnt == CW'(SLICES - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      i_ready    = 1'b0;
      o_valid    = 1'b0;
      unique case (state)
         IDLE: begin
            i_ready = 1'b1;
            if (i_valid) state_next = RUN;
         end
         RUN: begin
            if (last) state_next = DONE;
         end
         DONE: begin
            o_valid = 1'b1;
            if (o_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  // Subtraction is a + ~b + 1, so the carry starts at sub.
                  a_reg <= a;
                  b_reg <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
               end
            end
            RUN: begin
               result <= result_next;
               carry  <= slice_cout;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  c_out    <= slice_cout;
                  // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
                  overflow <= a_slice[W-1] ^ b_slice[W-1] ^ sum[W-1] ^ slice_cout;
                  zero     <= (result_next == '0);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial: vector table on N=32/W=8, plus backpressure, async reset
// and latency checks on W=32 and W=4 instances.

module tb_add_sub_serial;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_in, b_in;
   logic        sub_in;
   logic        iv   [3];
   logic        ir   [3];
   logic        ov   [3];
   logic        ordy [3];
   logic [31:0] res  [3];
   logic        co   [3];
   logic        ovf  [3];
   logic        zr   [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   add_sub_serial #(.N(32), .W(8)) u_dut_w8 (
      .clk(clk), .rst(rst), .i_valid(iv[0]), .i_ready(ir[0]), .a(a_in), .b(b_in), .sub(sub_in),
      .o_valid(ov[0]), .o_ready(ordy[0]), .result(res[0]), .c_out(co[0]), .overflow(ovf[0]),
      .zero(zr[0]));

   add_sub_serial #(.N(32), .W(32)) u_dut_w32 (
      .clk(clk), .rst(rst), .i_valid(iv[1]), .i_ready(ir[1]), .a(a_in), .b(b_in), .sub(sub_in),
      .o_valid(ov[1]), .o_ready(ordy[1]), .result(res[1]), .c_out(co[1]), .overflow(ovf[1]),
      .zero(zr[1]));

   add_sub_serial #(.N(32), .W(4)) u_dut_w4 (
      .clk(clk), .rst(rst), .i_valid(iv[2]), .i_ready(ir[2]), .a(a_in), .b(b_in), .sub(sub_in),
      .o_valid(ov[2]), .o_ready(ordy[2]), .result(res[2]), .c_out(co[2]), .overflow(ovf[2]),
      .zero(zr[2]));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] r;
      logic        c;
      logic        o;
      logic        z;
      string       nm;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic [31:0] er, input logic ec,
                         input logic eo, input logic ez, input int elat, input string nm);
      int lat;
      @(negedge clk);
      a_in = av; b_in = bv; sub_in = sv; iv[w] = 1'b1;
      check({nm, " i_ready"}, 32'(ir[w]), 32'd1);
      @(posedge clk);
      #1;
      iv[w] = 1'b0;
      // Scramble the operands: only the accepting edge may sample them.
      a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D; sub_in = ~sv;
      lat = 1;
      while (!ov[w] && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({nm, " latency"}, 32'(lat - 1), 32'(elat));
      check({nm, " result"}, res[w], er);
      check({nm, " c_out"}, 32'(co[w]), 32'(ec));
      check({nm, " overflow"}, 32'(ovf[w]), 32'(eo));
      check({nm, " zero"}, 32'(zr[w]), 32'(ez));
      ordy[w] = 1'b1;
      @(posedge clk);
      #1;
      ordy[w] = 1'b0;
      check({nm, " o_valid after accept"}, 32'(ov[w]), 32'd0);
      check({nm, " i_ready after accept"}, 32'(ir[w]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      vecs[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, "add_slice_carry"};
      vecs[1]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_equal"};
      vecs[2]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "sub_borrow"};
      vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "add_cout"};
      vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf"};
      vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sub_ovf"};
      vecs[6]  = '{32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0, "add_small"};
      vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, "add_neg_ovf"};
      vecs[8]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_negative"};
      vecs[9]  = '{32'h00FF_00FF, 32'h0001_FF01, 1'b0, 32'h0101_0000, 1'b0, 1'b0, 1'b0, "add_chain"};
      vecs[10] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "sub_min"};

      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0;
         ordy[i] = 1'b0;
      end
      a_in = '0; b_in = '0; sub_in = 1'b0;
      rst = 1'b0;
      #23;
      check("reset i_ready", 32'(ir[0]), 32'd1);
      check("reset o_valid", 32'(ov[0]), 32'd0);
      check("reset result", res[0], 32'd0);
      check("reset flags", {29'd0, co[0], ovf[0], zr[0]}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 11; i++)
         run_op(0, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].z,
                4, vecs[i].nm);

      // Reset in the middle of RUN, while the previous op left non-zero result and overflow.
      @(negedge clk);
      a_in = 32'h1111_1111; b_in = 32'h1111_1111; sub_in = 1'b0; iv[0] = 1'b1;
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrun_rst result", res[0], 32'd0);
      check("midrun_rst flags", {29'd0, co[0], ovf[0], zr[0]}, 32'd0);
      check("midrun_rst i_ready", 32'(ir[0]), 32'd1);
      check("midrun_rst o_valid", 32'(ov[0]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_op(0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 4, "post_rst_add");

      // Backpressure: hold the result for 5 cycles while a new request is offered.
      @(negedge clk);
      a_in = 32'd1; b_in = 32'd2; sub_in = 1'b0; iv[0] = 1'b1;
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      lat = 0;
      while (!ov[0] && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp o_valid", 32'(ov[0]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         iv[0] = 1'b1;
         a_in = 32'hCAFE_0000 + 32'(i);
         b_in = 32'h0000_1234;
         sub_in = 1'b1;
         @(posedge clk);
         #1;
         check("bp result held", res[0], 32'd3);
         check("bp flags held", {29'd0, co[0], ovf[0], zr[0]}, 32'd0);
         check("bp i_ready low", 32'(ir[0]), 32'd0);
         check("bp o_valid high", 32'(ov[0]), 32'd1);
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      ordy[0] = 1'b0;
      check("bp release i_ready", 32'(ir[0]), 32'd1);
      check("bp release o_valid", 32'(ov[0]), 32'd0);
      @(posedge clk);
      #1;
      check("bp idle stays idle", 32'(ir[0]), 32'd1);
      run_op(0, 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_000D, 1'b1, 1'b0, 1'b0, 4,
             "bp_second_op");

      // Latency follows N/W on the other slice widths.
      run_op(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1, "w32_add");
      run_op(2, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 8, "w4_add");
      run_op(2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 8, "w4_sub_ovf");
      run_op(1, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1, "w32_sub_eq");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/add_sub_serial.md
Name: add_sub_serial

Overview:
- Parametrised, multi-cycle adder/subtractor; successor to the single-cycle N-bit subtractor.
- Processes W bits per clock over N/W cycles, so wide operands cost only a W-bit adder slice.
- Per-operation add/sub mode, plus carry/borrow, signed overflow and zero flags.
- Sits between an operand source and a result consumer, using valid/ready handshakes on both sides.

Parameters:
N, 32, operand/result width in bits.
W, 8, slice width per cycle; N % W == 0 required, otherwise elaboration error ($error).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
i_valid  input  1  operands and mode valid.
i_ready  output  1  block can accept an operation.
a  input  N  minuend / augend.
b  input  N  subtrahend / addend.
sub  input  1  1 = a - b, 0 = a + b.
o_valid  output  1  result and flags valid.
o_ready  input  1  consumer accepts the result.
result  output  N  a+b or a-b, modulo 2^N.
c_out  output  1  carry out of the MSB; for sub, 1 = no borrow (a >= b unsigned).
overflow  output  1  two's-complement signed overflow.
zero  output  1  result == 0.

Behaviour:
- Reset (rst low, asynchronous, any state, including mid-operation):
  - State goes to IDLE; the in-flight operation is discarded.
  - i_ready=1, o_valid=0, result=0, c_out=0, overflow=0, zero=0.
  - Internal operand registers, carry and slice counter are cleared.
- State machine (IDLE, RUN, DONE):
  - IDLE: i_ready=1, o_valid=0. On i_valid & i_ready at a clock edge:
    - capture a into A_reg;
    - capture (sub ? ~b : b) into B_reg;
    - carry = sub, counter = 0;
    - go to RUN.
  - RUN: i_ready=0, o_valid=0. Each cycle:
    - slice k = A_reg[kW+:W] + B_reg[kW+:W] + carry;
    - slice k goes to result bits [kW+:W];
    - carry takes the slice carry-out; counter increments.
    - On the last slice (counter == N/W-1), also register:
      - c_out = final carry;
      - overflow = carry into bit N-1 XOR carry out of bit N-1;
      - zero = (full result == 0).
    - Then go to DONE.
  - DONE: o_valid=1, i_ready=0. result and flags are held stable while o_valid & !o_ready. On o_ready, go to IDLE.
- Latency and throughput:
  - Handshake at edge t gives o_valid high after edge t+N/W.
  - Minimum accept-to-accept spacing is N/W+2 cycles; no overlap or pipelining.
  - W == N gives a single RUN cycle.
- Outputs during IDLE/RUN:
  - result and flags keep the previous operation's values, except that result bits are overwritten slice-by-slice during RUN.
  - Consumers must sample result and flags only when o_valid=1.
- Inputs:
  - a, b and sub are sampled only at the accepting edge. Changes during RUN/DONE are ignored.
  - i_valid during RUN/DONE is not accepted; the producer holds it.
- Arithmetic:
  - Unsigned wrap modulo 2^N; no saturation.
  - Signed interpretation is reflected only in the overflow flag.
- Internal adder:
  - Uses the existing adder_n at width W (adder_n #(.N(W))), with c_in driven from the carry register.
  - The adder itself is purely combinational.

Test Plan:
N=32, W=8 unless noted.
1. Add: a=0x0000_00FF, b=0x0000_0001, sub=0 -> o_valid exactly 4 cycles after accept; result=0x0000_0100, c_out=0, overflow=0, zero=0. Carry must propagate across the slice boundary.
2. Sub, equal operands: a=b=0x1234_5678, sub=1 -> result=0, zero=1, c_out=1, overflow=0.
3. Sub with borrow: a=0, b=1, sub=1 -> result=0xFFFF_FFFF, c_out=0, overflow=0. Add carry-out: a=0xFFFF_FFFF, b=1, sub=0 -> result=0, c_out=1, zero=1.
4. Signed overflow:
   - a=0x7FFF_FFFF, b=1, add -> result=0x8000_0000, overflow=1.
   - a=0x8000_0000, b=1, sub -> result=0x7FFF_FFFF, overflow=1, c_out=1.
5. Backpressure and protocol: hold o_ready=0 for 5 cycles in DONE -> result/flags stable, i_ready=0, and new i_valid with different operands is ignored. Then o_ready=1 -> IDLE, i_ready=1 next cycle, and a second operation completes correctly.
6. Reset mid-RUN: assert rst low after slice 2 -> outputs go to reset values immediately (asynchronously), state IDLE. After release, a fresh add 3+4 yields 7. Repeat test 1 with W=32 (1 RUN cycle) and W=4 (8 RUN cycles) to confirm latency N/W.
